// File: rtl/stack_alu_seq.sv
// stack_alu_seq: clocked LIFO stack ALU.
// Holds DEPTH signed N-bit words and executes one stack instruction per
// accepted cycle. Result, overflow, error and occupancy are all registered,
// so every output reflects the instruction sampled at the previous edge.
module stack_alu_seq #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    opcode,
    input  logic          op_valid,
    input  logic [N-1:0]  input_data,
    output logic [N-1:0]  output_data,
    output logic          overflow,
    output logic          error,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_SUB  = 3'b001,
        OP_DUP  = 3'b010,
        OP_SWAP = 3'b011,
        OP_ADD  = 3'b100,
        OP_MUL  = 3'b101,
        OP_PUSH = 3'b110,
        OP_POP  = 3'b111
    } opcode_e;

    // A sign-extended (N+1)-bit sum/difference overflowed when its two top bits differ.
    function automatic logic ext_ovf(input logic [N:0] s);
        return s[N] ^ s[N-1];
    endfunction

    // A 2N-bit signed product fits in N bits only if its upper N+1 bits are all equal.
    function automatic logic mul_ovf(input logic [2*N-1:0] p);
        logic [N:0] upper;
        upper = p[2*N-1:N-1];
        return !((upper == {(N+1){1'b0}}) || (upper == {(N+1){1'b1}}));
    endfunction

    // Storage and registered state. Entry r_count-1 is the top of stack.
    logic [N-1:0]  r_stack [DEPTH];
    logic [CW-1:0] r_count;
    logic [N-1:0]  r_out;
    logic          r_ovf;
    logic          r_err;

    // Pointer-derived indices and occupancy flags.
    logic [CW-1:0] w_top_cnt;
    logic [CW-1:0] w_sec_cnt;
    logic [IW-1:0] w_top_idx;
    logic [IW-1:0] w_sec_idx;
    logic [IW-1:0] w_push_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_lt2;

    assign w_top_cnt  = r_count - CW'(1);
    assign w_sec_cnt  = r_count - CW'(2);
    assign w_top_idx  = w_top_cnt[IW-1:0];
    assign w_sec_idx  = w_sec_cnt[IW-1:0];
    assign w_push_idx = r_count[IW-1:0];
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == CW'(0));
    assign w_lt2      = (r_count < CW'(2));

    // Operands: A is the top entry, B the one below it.
    logic [N-1:0]   w_a;
    logic [N-1:0]   w_b;
    logic [N:0]     w_sum_ext;
    logic [N:0]     w_dif_ext;
    logic [2*N-1:0] w_a_ext;
    logic [2*N-1:0] w_b_ext;
    logic [2*N-1:0] w_prod;

    assign w_a       = r_stack[w_top_idx];
    assign w_b       = r_stack[w_sec_idx];
    assign w_sum_ext = {w_b[N-1], w_b} + {w_a[N-1], w_a};
    assign w_dif_ext = {w_b[N-1], w_b} - {w_a[N-1], w_a};
    // Low 2N bits of the product of sign-extended operands equal the signed product.
    assign w_a_ext   = {{N{w_a[N-1]}}, w_a};
    assign w_b_ext   = {{N{w_b[N-1]}}, w_b};
    assign w_prod    = w_b_ext * w_a_ext;

    logic [N-1:0] w_alu_res;
    logic         w_alu_ovf;

    // Select the arithmetic result and its overflow flag for ADD/SUB/MUL.
    always_comb begin
        w_alu_res = w_sum_ext[N-1:0];
        w_alu_ovf = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_res = w_sum_ext[N-1:0];
                w_alu_ovf = ext_ovf(w_sum_ext);
            end
            OP_SUB: begin
                w_alu_res = w_dif_ext[N-1:0];
                w_alu_ovf = ext_ovf(w_dif_ext);
            end
            OP_MUL: begin
                w_alu_res = w_prod[N-1:0];
                w_alu_ovf = mul_ovf(w_prod);
            end
            default: begin
                w_alu_res = w_sum_ext[N-1:0];
                w_alu_ovf = 1'b0;
            end
        endcase
    end

    logic [CW-1:0] w_nxt_count;
    logic [N-1:0]  w_nxt_out;
    logic          w_nxt_ovf;
    logic          w_nxt_err;
    logic          w_wr0_en;
    logic [IW-1:0] w_wr0_idx;
    logic [N-1:0]  w_wr0_data;
    logic          w_wr1_en;
    logic [IW-1:0] w_wr1_idx;
    logic [N-1:0]  w_wr1_data;

    // Decode the instruction into next state and up to two storage writes.
    // Illegal instructions leave everything untouched except the error pulse.
    always_comb begin
        w_nxt_count = r_count;
        w_nxt_out   = r_out;
        w_nxt_ovf   = r_ovf;
        w_nxt_err   = 1'b0;
        w_wr0_en    = 1'b0;
        w_wr0_idx   = w_push_idx;
        w_wr0_data  = input_data;
        w_wr1_en    = 1'b0;
        w_wr1_idx   = w_sec_idx;
        w_wr1_data  = w_a;
        if (op_valid) begin
            case (opcode)
                OP_NOP: begin
                    w_nxt_err = 1'b0;
                end
                OP_PUSH: begin
                    if (w_full) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_wr0_en    = 1'b1;
                        w_wr0_idx   = w_push_idx;
                        w_wr0_data  = input_data;
                        w_nxt_count = r_count + CW'(1);
                        w_nxt_out   = input_data;
                        w_nxt_ovf   = 1'b0;
                    end
                end
                OP_POP: begin
                    if (w_empty) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_nxt_count = r_count - CW'(1);
                        w_nxt_out   = w_a;
                        w_nxt_ovf   = 1'b0;
                    end
                end
                OP_DUP: begin
                    if (w_full || w_empty) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_wr0_en    = 1'b1;
                        w_wr0_idx   = w_push_idx;
                        w_wr0_data  = w_a;
                        w_nxt_count = r_count + CW'(1);
                        w_nxt_out   = w_a;
                        w_nxt_ovf   = 1'b0;
                    end
                end
                OP_SWAP: begin
                    if (w_lt2) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        w_wr0_en   = 1'b1;
                        w_wr0_idx  = w_top_idx;
                        w_wr0_data = w_b;
                        w_wr1_en   = 1'b1;
                        w_wr1_idx  = w_sec_idx;
                        w_wr1_data = w_a;
                        w_nxt_out  = w_b;
                        w_nxt_ovf  = 1'b0;
                    end
                end
                OP_ADD, OP_SUB, OP_MUL: begin
                    if (w_lt2) begin
                        w_nxt_err = 1'b1;
                    end else begin
                        // R replaces B; A is dropped by the count decrement.
                        w_wr1_en    = 1'b1;
                        w_wr1_idx   = w_sec_idx;
                        w_wr1_data  = w_alu_res;
                        w_nxt_count = r_count - CW'(1);
                        w_nxt_out   = w_alu_res;
                        w_nxt_ovf   = w_alu_ovf;
                    end
                end
                default: begin
                    w_nxt_err = 1'b0;
                end
            endcase
        end else begin
            w_nxt_err = 1'b0;
        end
    end

    // Control/result registers; reset takes priority over any instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= CW'(0);
            r_out   <= {N{1'b0}};
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_out   <= w_nxt_out;
            r_ovf   <= w_nxt_ovf;
            r_err   <= w_nxt_err;
        end
    end

    // Stack storage: never cleared, but writes are suppressed while in reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_wr0_en) begin
                r_stack[w_wr0_idx] <= w_wr0_data;
            end
            if (w_wr1_en) begin
                r_stack[w_wr1_idx] <= w_wr1_data;
            end
        end
    end

    assign output_data = r_out;
    assign overflow    = r_ovf;
    assign error       = r_err;
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;

endmodule

// File: tb/tb_stack_alu_seq.sv
// tb_stack_alu_seq: directed scenarios plus randomized instruction stream,
// checked cycle by cycle against a queue-based reference model.
module tb_stack_alu_seq;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam longint MAXV = 32767;
    localparam longint MINV = -32768;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] SUB  = 3'b001;
    localparam logic [2:0] DUP  = 3'b010;
    localparam logic [2:0] SWAP = 3'b011;
    localparam logic [2:0] ADD  = 3'b100;
    localparam logic [2:0] MUL  = 3'b101;
    localparam logic [2:0] PUSH = 3'b110;
    localparam logic [2:0] POP  = 3'b111;

    logic          clk;
    logic          rst;
    logic [2:0]    opcode;
    logic          op_valid;
    logic [N-1:0]  input_data;
    logic [N-1:0]  output_data;
    logic          overflow;
    logic          error;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;

    stack_alu_seq #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .op_valid(op_valid),
        .input_data(input_data), .output_data(output_data),
        .overflow(overflow), .error(error), .full(full), .empty(empty),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: signed values, top of stack at the queue tail.
    int q[$];
    int m_out = 0;
    bit m_ovf = 1'b0;
    bit m_err = 1'b0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap(input longint v);
        longint m;
        m = v & 64'hFFFF;
        if (m >= 64'sd32768) m = m - 64'sd65536;
        return int'(m);
    endfunction

    task automatic model(input bit r, input bit v, input logic [2:0] op, input logic [N-1:0] d);
        int n;
        int a;
        int b;
        longint ex;
        if (r) begin
            q.delete();
            m_out = 0;
            m_ovf = 1'b0;
            m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (!v) return;
        n = q.size();
        a = (n > 0) ? q[n-1] : 0;
        b = (n > 1) ? q[n-2] : 0;
        case (op)
            PUSH: if (n == DEPTH) m_err = 1'b1;
                  else begin q.push_back(wrap(longint'(d))); m_out = wrap(longint'(d)); m_ovf = 1'b0; end
            POP:  if (n == 0) m_err = 1'b1;
                  else begin m_out = q.pop_back(); m_ovf = 1'b0; end
            DUP:  if (n == 0 || n == DEPTH) m_err = 1'b1;
                  else begin q.push_back(a); m_out = a; m_ovf = 1'b0; end
            SWAP: if (n < 2) m_err = 1'b1;
                  else begin q[n-1] = b; q[n-2] = a; m_out = b; m_ovf = 1'b0; end
            ADD, SUB, MUL: begin
                if (n < 2) m_err = 1'b1;
                else begin
                    if (op == ADD)      ex = longint'(b) + longint'(a);
                    else if (op == SUB) ex = longint'(b) - longint'(a);
                    else                ex = longint'(b) * longint'(a);
                    void'(q.pop_back());
                    void'(q.pop_back());
                    q.push_back(wrap(ex));
                    m_out = wrap(ex);
                    m_ovf = (ex > MAXV) || (ex < MINV);
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        check_eq("out",   longint'(output_data), longint'(m_out) & 64'hFFFF);
        check_eq("ovf",   longint'(overflow), longint'(m_ovf));
        check_eq("err",   longint'(error), longint'(m_err));
        check_eq("cnt",   longint'(count), longint'(q.size()));
        check_eq("full",  longint'(full), longint'(q.size() == DEPTH));
        check_eq("empty", longint'(empty), longint'(q.size() == 0));
    endtask

    task automatic step(input bit r, input bit v, input logic [2:0] op, input logic [N-1:0] d);
        @(negedge clk);
        rst = r; op_valid = v; opcode = op; input_data = d;
        @(posedge clk);
        model(r, v, op, d);
        #1;
        check_all();
    endtask

    task automatic op1(input logic [2:0] op, input logic [N-1:0] d);
        step(1'b0, 1'b1, op, d);
    endtask

    initial begin
        logic [N-1:0] d;
        logic [2:0]   op;
        int           sel;
        rst = 1'b1; op_valid = 1'b0; opcode = NOP; input_data = '0;
        step(1'b1, 1'b0, NOP, 16'h0000);
        step(1'b1, 1'b0, NOP, 16'h0000);
        check_eq("rst_out", longint'(output_data), 0);
        check_eq("rst_empty", longint'(empty), 1);
        check_eq("rst_cnt", longint'(count), 0);

        // Arithmetic
        op1(PUSH, 16'd10); op1(PUSH, 16'd20); op1(ADD, 16'd0);
        check_eq("tp_add", longint'(output_data), 30);
        check_eq("tp_add_cnt", longint'(count), 1);
        op1(PUSH, 16'd5); op1(PUSH, 16'd7); op1(SUB, 16'd0);
        check_eq("tp_sub", longint'(output_data), 64'h0000_0000_0000_FFFE);
        check_eq("tp_sub_cnt", longint'(count), 2);

        // MUL and POP
        step(1'b1, 1'b0, NOP, 16'h0000);
        op1(PUSH, 16'd3); op1(PUSH, 16'd4); op1(MUL, 16'd0);
        check_eq("tp_mul", longint'(output_data), 12);
        check_eq("tp_mul_ovf", longint'(overflow), 0);
        op1(POP, 16'd0);
        check_eq("tp_pop", longint'(output_data), 12);
        check_eq("tp_pop_cnt", longint'(count), 0);

        // Overflow
        op1(PUSH, 16'h7FFF); op1(PUSH, 16'h0001); op1(ADD, 16'd0);
        check_eq("tp_addovf", longint'(output_data), 64'h8000);
        check_eq("tp_addovf_f", longint'(overflow), 1);
        op1(PUSH, 16'h8000); op1(PUSH, 16'h0002); op1(MUL, 16'd0);
        check_eq("tp_mulovf", longint'(output_data), 0);
        check_eq("tp_mulovf_f", longint'(overflow), 1);
        op1(PUSH, 16'h0001);
        check_eq("tp_ovf_clr", longint'(overflow), 0);

        // Full and empty boundaries
        step(1'b1, 1'b0, NOP, 16'h0000);
        for (int i = 1; i <= 8; i++) op1(PUSH, N'(i));
        check_eq("tp_full", longint'(full), 1);
        check_eq("tp_full_cnt", longint'(count), 8);
        op1(PUSH, 16'd99);
        check_eq("tp_ovr_err", longint'(error), 1);
        check_eq("tp_ovr_cnt", longint'(count), 8);
        op1(POP, 16'd0);
        check_eq("tp_ovr_pop", longint'(output_data), 8);
        check_eq("tp_err_drop", longint'(error), 0);
        for (int i = 0; i < 7; i++) op1(POP, 16'd0);
        check_eq("tp_empty", longint'(empty), 1);
        op1(POP, 16'd0);
        check_eq("tp_und_err", longint'(error), 1);
        check_eq("tp_und_hold", longint'(output_data), 1);

        // DUP and SWAP
        op1(PUSH, 16'd1); op1(PUSH, 16'd2); op1(SWAP, 16'd0);
        check_eq("tp_swap", longint'(output_data), 1);
        op1(POP, 16'd0);
        check_eq("tp_swap_p1", longint'(output_data), 1);
        op1(POP, 16'd0);
        check_eq("tp_swap_p2", longint'(output_data), 2);
        op1(DUP, 16'd0);
        check_eq("tp_dup_err", longint'(error), 1);

        // Reset during an instruction, then idle
        op1(PUSH, 16'd5); op1(PUSH, 16'd6);
        step(1'b1, 1'b1, ADD, 16'd0);
        check_eq("tp_rst_cnt", longint'(count), 0);
        check_eq("tp_rst_out", longint'(output_data), 0);
        op1(PUSH, 16'd9);
        step(1'b0, 1'b0, PUSH, 16'd77);
        check_eq("tp_idle_out", longint'(output_data), 9);
        check_eq("tp_idle_cnt", longint'(count), 1);

        // Randomized stream
        for (int k = 0; k < 3000; k++) begin
            sel = $urandom_range(0, 15);
            case (sel)
                0, 1, 2, 3, 4, 15: op = PUSH;
                5, 6, 14:          op = POP;
                7:                 op = DUP;
                8:                 op = SWAP;
                9, 10:             op = ADD;
                11:                op = SUB;
                12:                op = MUL;
                default:           op = NOP;
            endcase
            case ($urandom_range(0, 5))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                2:       d = N'($urandom_range(0, 7));
                3:       d = 16'hFFFF;
                default: d = N'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0), op, d);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/stack_alu_seq.md
# stack_alu_seq

Clocked, parametrised successor to the combinational-style stack ALU. It holds a LIFO of `DEPTH` signed `N`-bit words and executes one stack instruction per accepted cycle. Instructions include push, pop, add, multiply, subtract, duplicate, swap and no-op. It reports registered result, signed arithmetic overflow, stack full/empty, occupancy, and a one-cycle error pulse for illegal operations. It sits between an instruction sequencer and downstream consumers that read the top-of-stack result.

## Interface
- `N`, 16, data word width in bits (≥2).
- `DEPTH`, 8, stack entries (≥2).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  3  instruction; encodings below.
- `op_valid`  in  1  instruction accepted on a rising edge when high.
- `input_data`  in  N  operand for PUSH; ignored otherwise.
- `output_data`  out  N  registered result / top-of-stack value.
- `overflow`  out  1  registered signed-overflow flag of the last arithmetic op.
- `error`  out  1  one-cycle pulse: the last accepted instruction was illegal.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Opcodes: 000 NOP, 001 SUB, 010 DUP, 011 SWAP, 100 ADD, 101 MUL, 110 PUSH, 111 POP. 100/101/110/111 are unchanged from the previous generation.
- A = top entry, B = entry below top. All arithmetic is two's complement signed.
- PUSH:
  - Write `input_data` on top; count+1.
  - `output_data` = `input_data`; overflow cleared.
- POP:
  - Remove top; count−1.
  - `output_data` = A; overflow cleared.
- DUP:
  - Push copy of A; count+1.
  - `output_data` = A; overflow cleared.
- SWAP:
  - Exchange A and B; count unchanged.
  - `output_data` = B (new top); overflow cleared.
- ADD / SUB / MUL:
  - Pop A and B, push R; count−1; `output_data` = R.
  - R = B+A, B−A, or B×A, truncated to low N bits.
  - ADD/SUB `overflow` = 1 iff the exact signed result lies outside [−2^(N−1), 2^(N−1)−1].
  - MUL: compute the full 2N-bit signed product; `overflow` = 1 iff its upper N+1 bits are not all equal.
- NOP: no state change; `output_data` and `overflow` hold; error = 0.
- Illegal cases:
  - PUSH or DUP when full.
  - POP or DUP when empty.
  - SWAP, ADD, SUB or MUL with count < 2.
  - Required response: stack and count unchanged, `output_data` and `overflow` hold, `error` = 1 for exactly the following cycle.
- `op_valid` = 0: all state holds; `error` = 0.
- Stack storage is a register array indexed by a pointer. Contents of unoccupied entries are don't-care.

## Timing
- Reset values:
  - `output_data` = 0, `overflow` = 0, `error` = 0.
  - `count` = 0, `empty` = 1, `full` = 0.
  - Storage contents are not cleared.
- `rst` dominates `op_valid`: reset asserted during any instruction discards that instruction.
- Latency is one cycle. An instruction sampled at edge k has all outputs, including `full`/`empty`/`count`, valid after edge k and stable until edge k+1.
- Throughput is one instruction per cycle, with no stall and no back-pressure. Back-to-back dependent ops use the updated stack immediately, e.g. PUSH then ADD on consecutive cycles.
- `error` is registered and deasserts on the next edge unless another illegal op is accepted.
- `full` and `empty` are derived from the registered count; they are never both 1.

## Test plan
- Arithmetic, N=16, DEPTH=8:
  - PUSH 10, PUSH 20, ADD → `output_data`=30 (0x001E), overflow=0, count=1.
  - Then PUSH 5, PUSH 7, SUB → 0xFFFE (−2), overflow=0, count=2.
- MUL and POP: PUSH 3, PUSH 4, MUL → 12, overflow=0. Then POP → `output_data`=12, count decremented by 1.
- Overflow:
  - PUSH 0x7FFF, PUSH 1, ADD → 0x8000, overflow=1.
  - PUSH 0x8000, PUSH 2, MUL → 0x0000, overflow=1.
  - A following PUSH clears overflow to 0.
- Full and empty boundaries:
  - 8 PUSHes of 1..8 → full=1, count=8.
  - 9th PUSH 99 → error pulse of one cycle, count=8; the next POP returns 8.
  - Pop to empty (empty=1); a further POP → error pulse, `output_data` holds last value.
- DUP and SWAP: PUSH 1, PUSH 2, SWAP → `output_data`=1. Then POP → 1, POP → 2, DUP with empty stack → error=1.
- Reset and idle:
  - PUSH 5, PUSH 6, then assert `rst` in the same cycle as an ADD → next cycle count=0, `output_data`=0, overflow=0, error=0.
  - `op_valid`=0 with opcode=PUSH → no change.
